// File: rtl/feeder_pkg.sv
// ============================================================================
// Module : feeder_pkg
// Brief  : Shared scancodes, FSM state and playback direction types for the
//          flash sample feeder.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package feeder_pkg;

    localparam logic [7:0] KEY_F = 8'h46;
    localparam logic [7:0] KEY_B = 8'h42;
    localparam logic [7:0] KEY_R = 8'h52;

    typedef enum logic [2:0] {
        ST_REQ        = 3'd0,
        ST_WAIT_VALID = 3'd1,
        ST_FIRST      = 3'd2,
        ST_SECOND     = 3'd3,
        ST_ADVANCE    = 3'd4
    } state_t;

    typedef enum logic {
        DIR_FWD = 1'b0,
        DIR_BWD = 1'b1
    } dir_t;

    // Codes other than F/B leave the direction untouched (R included).
    function automatic dir_t next_dir(input logic [7:0] key, input dir_t cur);
        dir_t d;
        d = cur;
        if (key == KEY_F) begin
            d = DIR_FWD;
        end else if (key == KEY_B) begin
            d = DIR_BWD;
        end
        return d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/addr_stepper.sv
// ============================================================================
// Module : addr_stepper
// Brief  : Flash word-address register with forward/backward wrap and restart.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module addr_stepper
    import feeder_pkg::*;
#(
    parameter int          ADDR_WIDTH = 23,
    parameter int unsigned ADDR_MAX   = 'h7FFFF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_step,
    input  dir_t                  i_dir,
    input  logic                  i_restart,
    output logic [ADDR_WIDTH-1:0] o_addr
);

    localparam logic [ADDR_WIDTH-1:0] c_addr_max = ADDR_WIDTH'(ADDR_MAX);

    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] w_addr_next;

    // Out-of-range compares keep the register inside [0, ADDR_MAX] even if it
    // were ever disturbed.
    always_comb begin
        w_addr_next = r_addr;
        if (i_restart) begin
            w_addr_next = (i_dir == DIR_FWD) ? '0 : c_addr_max;
        end else if (i_dir == DIR_FWD) begin
            w_addr_next = (r_addr >= c_addr_max) ? '0 : r_addr + ADDR_WIDTH'(1);
        end else begin
            w_addr_next = ((r_addr == '0) || (r_addr > c_addr_max)) ?
                          c_addr_max : r_addr - ADDR_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr <= '0;
        end else if (i_step) begin
            r_addr <= w_addr_next;
        end
    end

    assign o_addr = r_addr;

endmodule

`default_nettype wire

// File: rtl/flash_sample_feeder.sv
// ============================================================================
// Module : flash_sample_feeder
// Brief  : Reads 32-bit flash words over Avalon-MM and hands them downstream
//          as two 16-bit samples, direction and restart chosen by scancode.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module flash_sample_feeder
    import feeder_pkg::*;
#(
    parameter int          ADDR_WIDTH   = 23,
    parameter int unsigned ADDR_MAX     = 'h7FFFF,
    parameter int          SAMPLE_WIDTH = 16
) (
    input  logic                      clock50,
    input  logic                      rstn,
    input  logic                      confirm_pass,
    input  logic [7:0]                key_control,
    output logic [SAMPLE_WIDTH-1:0]   getdata,
    output logic                      data_ready,
    output logic                      flash_mem_read,
    output logic [ADDR_WIDTH-1:0]     flash_mem_address,
    output logic [3:0]                flash_mem_byteenable,
    input  logic                      flash_mem_waitrequest,
    input  logic [2*SAMPLE_WIDTH-1:0] flash_mem_readdata,
    input  logic                      flash_mem_readdatavalid
);

    state_t                    r_state;
    state_t                    w_next_state;
    dir_t                      r_dir;
    dir_t                      w_dir_next;
    logic                      r_read;
    logic                      r_data_ready;
    logic [SAMPLE_WIDTH-1:0]   r_getdata;
    logic [2*SAMPLE_WIDTH-1:0] r_word;

    logic                      w_capture;
    logic                      w_take_first;
    logic                      w_take_second;
    logic                      w_step;
    logic                      w_restart;
    logic                      w_read_next;
    logic [ADDR_WIDTH-1:0]     w_addr;

    always_ff @(posedge clock50 or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_REQ;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_REQ:        if (r_read && !flash_mem_waitrequest) w_next_state = ST_WAIT_VALID;
            ST_WAIT_VALID: if (flash_mem_readdatavalid)           w_next_state = ST_FIRST;
            ST_FIRST:      if (confirm_pass)                      w_next_state = ST_SECOND;
            ST_SECOND:     if (confirm_pass)                      w_next_state = ST_ADVANCE;
            ST_ADVANCE:                                           w_next_state = ST_REQ;
            default:                                              w_next_state = ST_REQ;
        endcase
    end

    // Read is registered so it is low on the first cycle out of reset and
    // drops on the same edge the request is accepted.
    always_comb begin
        w_capture     = (r_state == ST_WAIT_VALID) && flash_mem_readdatavalid;
        w_take_first  = (r_state == ST_FIRST)  && confirm_pass;
        w_take_second = (r_state == ST_SECOND) && confirm_pass;
        w_step        = (r_state == ST_ADVANCE);
        w_read_next   = (w_next_state == ST_REQ);
    end

    assign w_dir_next = next_dir(key_control, r_dir);
    assign w_restart  = (key_control == KEY_R);

    always_ff @(posedge clock50 or negedge rstn) begin
        if (!rstn) begin
            r_read       <= 1'b0;
            r_data_ready <= 1'b0;
            r_getdata    <= '0;
            r_word       <= '0;
            r_dir        <= DIR_FWD;
        end else begin
            r_read <= w_read_next;
            if (w_capture) begin
                r_word       <= flash_mem_readdata;
                r_getdata    <= (r_dir == DIR_FWD) ? flash_mem_readdata[SAMPLE_WIDTH-1:0]
                                                   : flash_mem_readdata[2*SAMPLE_WIDTH-1:SAMPLE_WIDTH];
                r_data_ready <= 1'b1;
            end
            if (w_take_first) begin
                r_getdata <= (r_dir == DIR_FWD) ? r_word[2*SAMPLE_WIDTH-1:SAMPLE_WIDTH]
                                                : r_word[SAMPLE_WIDTH-1:0];
            end
            if (w_take_second) begin
                r_data_ready <= 1'b0;
            end
            if (w_step) begin
                r_dir <= w_dir_next;
            end
        end
    end

    addr_stepper #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .ADDR_MAX   (ADDR_MAX)
    ) u_addr_stepper (
        .clk       (clock50),
        .rst_n     (rstn),
        .i_step    (w_step),
        .i_dir     (w_dir_next),
        .i_restart (w_restart),
        .o_addr    (w_addr)
    );

    assign getdata              = r_getdata;
    assign data_ready           = r_data_ready;
    assign flash_mem_read       = r_read;
    assign flash_mem_address    = w_addr;
    assign flash_mem_byteenable = 4'b1111;

endmodule

`default_nettype wire

// File: tb/tb_flash_sample_feeder.sv
// ============================================================================
// Module : tb_flash_sample_feeder
// Brief  : Bench for flash_sample_feeder with a flash slave and sample model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_flash_sample_feeder;

    localparam int MAXA = 'h7FFFF;

    logic        clk;
    logic        rstn;
    logic        confirm;
    logic [7:0]  key;
    logic [15:0] getdata;
    logic        data_ready;
    logic        rd;
    logic [22:0] addr;
    logic [3:0]  be;
    logic        waitreq;
    logic [31:0] rdata;
    logic        rvalid;

    int n_cmp = 0;
    int n_err = 0;

    flash_sample_feeder dut (
        .clock50                 (clk),
        .rstn                    (rstn),
        .confirm_pass            (confirm),
        .key_control             (key),
        .getdata                 (getdata),
        .data_ready              (data_ready),
        .flash_mem_read          (rd),
        .flash_mem_address       (addr),
        .flash_mem_byteenable    (be),
        .flash_mem_waitrequest   (waitreq),
        .flash_mem_readdata      (rdata),
        .flash_mem_readdatavalid (rvalid)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    function automatic logic [31:0] memword(input int a);
        logic [31:0] v;
        if (a == 0)         return 32'hBBBBAAAA;
        if (a == MAXA)      return 32'h22221111;
        v = a;
        return {v[15:0] ^ 16'hA5A5, v[15:0] ^ 16'h0F0F};
    endfunction

    // ---------------- flash slave ----------------
    int          stall_cfg = 0;
    int          lat_cfg   = 1;
    logic        inject    = 1'b0;
    int          stall_left;
    int          lat_left;
    logic        pend;
    logic [22:0] p_addr;

    assign waitreq = (stall_left != 0);

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_left <= stall_cfg;
            lat_left   <= 0;
            pend       <= 1'b0;
            rvalid     <= 1'b0;
            rdata      <= '0;
            p_addr     <= '0;
        end else begin
            rvalid <= 1'b0;
            if (inject) begin
                rvalid <= 1'b1;
                rdata  <= 32'hDEADBEEF;
            end
            if (!rd)                  stall_left <= stall_cfg;
            else if (stall_left != 0) stall_left <= stall_left - 1;
            else begin
                pend     <= 1'b1;
                lat_left <= lat_cfg;
                p_addr   <= addr;
            end
            if (pend) begin
                if (lat_left == 0) begin
                    rvalid <= 1'b1;
                    rdata  <= memword(int'(p_addr));
                    pend   <= 1'b0;
                end else begin
                    lat_left <= lat_left - 1;
                end
            end
        end
    end

    // ---------------- behavioural model ----------------
    int          m_addr;
    logic        m_dir;     // 0 fwd, 1 bwd
    logic        m_wait, m_ready, m_half, m_adv, m_stalled;
    logic [31:0] m_word;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_addr = 0; m_dir = 1'b0; m_wait = 1'b0; m_ready = 1'b0;
            m_half = 1'b0; m_adv = 1'b0; m_stalled = 1'b0; m_word = '0;
        end else begin
            m_stalled = rd && waitreq;
            if (m_adv) begin
                if (key == 8'h46) m_dir = 1'b0;
                if (key == 8'h42) m_dir = 1'b1;
                if (key == 8'h52)  m_addr = m_dir ? MAXA : 0;
                else if (!m_dir)   m_addr = (m_addr + 1) % (MAXA + 1);
                else               m_addr = (m_addr + MAXA) % (MAXA + 1);
                m_adv = 1'b0;
            end
            if (rd && !waitreq) begin
                m_wait = 1'b1;
            end else if (m_wait && rvalid) begin
                m_word  = rdata;
                m_wait  = 1'b0;
                m_ready = 1'b1;
                m_half  = 1'b0;
            end else if (m_ready && confirm) begin
                if (!m_half) m_half = 1'b1;
                else begin
                    m_ready = 1'b0;
                    m_adv   = 1'b1;
                end
            end
        end
    end

    function automatic logic [15:0] exp_sample();
        return (m_half ^ m_dir) ? m_word[31:16] : m_word[15:0];
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (rstn) begin
            cmp("data_ready", {31'd0, data_ready}, {31'd0, m_ready});
            if (m_ready) cmp("getdata", {16'd0, getdata}, {16'd0, exp_sample()});
            if (rd) cmp("address", {9'd0, addr}, m_addr);
            if (m_stalled) cmp("read_held", {31'd0, rd}, 32'd1);
            if (m_wait || m_ready) cmp("read_idle", {31'd0, rd}, 32'd0);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic pulse();
        confirm = 1'b1;
        @(negedge clk);
        confirm = 1'b0;
    endtask

    task automatic wait_accept(input int exp_addr);
        for (int i = 0; i < 300; i++) begin
            if (rd && !waitreq) begin
                cmp("req_addr", {9'd0, addr}, exp_addr);
                return;
            end
            @(negedge clk);
        end
        cmp("req_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 300; i++) begin
            if (data_ready) return;
            @(negedge clk);
        end
        cmp("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_reset();
        cmp("rst_ready", {31'd0, data_ready}, 32'd0);
        cmp("rst_getdata", {16'd0, getdata}, 32'd0);
        cmp("rst_read", {31'd0, rd}, 32'd0);
        cmp("rst_addr", {9'd0, addr}, 32'd0);
    endtask

    initial begin
        int stalls;
        rstn = 1'b0; confirm = 1'b0; key = 8'h00;
        repeat (3) @(negedge clk);
        check_reset();
        cmp("byteenable", {28'd0, be}, 32'hF);
        rstn = 1'b1;

        // word at 0, forward
        wait_accept(0);
        @(negedge clk);
        wait_ready();
        cmp("w0_lo", {16'd0, getdata}, 32'hAAAA);
        pulse();
        cmp("w0_hi", {16'd0, getdata}, 32'hBBBB);
        cmp("w0_ready", {31'd0, data_ready}, 32'd1);
        pulse();

        // five wait states on the request for word 1
        stall_cfg = 5;
        stalls = 0;
        for (int i = 0; i < 50 && !(rd && !waitreq); i++) begin
            if (rd && waitreq) stalls++;
            @(negedge clk);
        end
        cmp("stall_cycles", stalls, 32'd5);
        wait_accept(1);
        stall_cfg = 0;
        @(negedge clk);
        wait_ready();
        cmp("w1_lo", {16'd0, getdata}, 32'h0F0E);
        pulse();
        key = 8'h42;           // B mid-word: second half still forward
        cmp("w1_hi", {16'd0, getdata}, 32'hA5A4);
        pulse();

        // backward: 0 then wrap to ADDR_MAX
        wait_accept(0);
        @(negedge clk);
        wait_ready();
        cmp("b0_hi", {16'd0, getdata}, 32'hBBBB);
        pulse();
        cmp("b0_lo", {16'd0, getdata}, 32'hAAAA);
        pulse();
        wait_accept(MAXA);
        @(negedge clk);
        wait_ready();
        cmp("bmax_hi", {16'd0, getdata}, 32'h2222);
        pulse();
        key = 8'h46;
        cmp("bmax_lo", {16'd0, getdata}, 32'h1111);
        pulse();

        // forward from ADDR_MAX wraps to 0, then walk up to 'h100
        wait_accept(0);
        key = 8'h23;
        for (int w = 0; w < 256; w++) begin
            @(negedge clk);
            wait_ready();
            if (w == 5) begin
                inject = 1'b1;
                @(negedge clk);
                inject = 1'b0;
            end
            pulse();
            pulse();
        end
        wait_accept('h100);
        @(negedge clk);
        wait_ready();
        pulse();
        key = 8'h52;           // restart mid-word
        cmp("r_hi", {16'd0, getdata}, 32'hA4A5);
        pulse();
        @(negedge clk);
        key = 8'h00;
        wait_accept(0);
        @(negedge clk);
        wait_ready();
        cmp("r_w0_lo", {16'd0, getdata}, 32'hAAAA);
        pulse();
        pulse();

        // confirm and reset during WAIT_VALID
        lat_cfg = 6;
        wait_accept(1);
        @(negedge clk);
        confirm = 1'b1;
        @(negedge clk);
        confirm = 1'b0;
        cmp("wv_ready", {31'd0, data_ready}, 32'd0);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        check_reset();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        lat_cfg = 1;
        wait_accept(0);
        @(negedge clk);
        wait_ready();
        cmp("post_rst_lo", {16'd0, getdata}, 32'hAAAA);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
